// File: rtl/alu_compare_unit.sv
// RV32I execute core: 32-bit ALU plus funct3-selected branch comparator, with an EX/MEM result register.
// Latency: result/cond are combinational (0 cycles); result_q/cond_q/valid_q follow one cycle later.
// Backpressure: none; the register captures on every edge and consumers qualify it with valid_q.
module alu_compare_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  alu_op,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    input  logic [2:0]  funct3,
    input  logic        in_valid,
    output logic [31:0] result,
    output logic        cond,
    output logic [31:0] result_q,
    output logic        cond_q,
    output logic        valid_q
);

    // ALU operation encodings
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    // Branch condition encodings (funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Only the low five bits of operand B act as the shift amount.
    logic [4:0]  shamt;
    logic        alu_lt_s;
    logic        alu_lt_u;
    logic        cmp_eq;
    logic        cmp_lt_s;
    logic        cmp_lt_u;
    logic [31:0] sra_res;

    assign shamt    = in2[4:0];
    assign alu_lt_s = $signed(in1) < $signed(in2);
    assign alu_lt_u = in1 < in2;
    assign sra_res  = $signed(in1) >>> shamt;

    assign cmp_eq   = cmp_a == cmp_b;
    assign cmp_lt_s = $signed(cmp_a) < $signed(cmp_b);
    assign cmp_lt_u = cmp_a < cmp_b;

    // ALU result select; unused encodings return zero.
    always_comb begin
        result = 32'd0;
        case (alu_op)
            OP_ADD:   result = in1 + in2;
            OP_SUB:   result = in1 - in2;
            OP_SLL:   result = in1 << shamt;
            OP_SLT:   result = {31'd0, alu_lt_s};
            OP_SLTU:  result = {31'd0, alu_lt_u};
            OP_XOR:   result = in1 ^ in2;
            OP_SRL:   result = in1 >> shamt;
            OP_SRA:   result = sra_res;
            OP_OR:    result = in1 | in2;
            OP_AND:   result = in1 & in2;
            OP_PASSB: result = in2;
            default:  result = 32'd0;
        endcase
    end

    // Branch condition select; reserved funct3 values never take the branch.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = cmp_eq;
            F3_BNE:  cond = ~cmp_eq;
            F3_BLT:  cond = cmp_lt_s;
            F3_BGE:  cond = ~cmp_lt_s;
            F3_BLTU: cond = cmp_lt_u;
            F3_BGEU: cond = ~cmp_lt_u;
            default: cond = 1'b0;
        endcase
    end

    // EX/MEM capture every cycle regardless of in_valid; valid_q qualifies the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 32'd0;
            cond_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result;
            cond_q   <= cond;
            valid_q  <= in_valid;
        end
    end

endmodule

// File: tb/tb_alu_compare_unit.sv
// Directed table-driven bench for alu_compare_unit: ALU and comparator vectors plus reset sequences.
// Inputs change just after the falling edge; outputs are sampled 1 time unit after either edge.
// No backpressure in the design; the bench simply steps one vector per clock.
module tb_alu_compare_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  alu_op;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [2:0]  funct3;
    logic        in_valid;
    logic [31:0] result;
    logic        cond;
    logic [31:0] result_q;
    logic        cond_q;
    logic        valid_q;

    int checks;
    int failures;

    alu_compare_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in1      (in1),
        .in2      (in2),
        .alu_op   (alu_op),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .funct3   (funct3),
        .in_valid (in_valid),
        .result   (result),
        .cond     (cond),
        .result_q (result_q),
        .cond_q   (cond_q),
        .valid_q  (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } cmp_vec_t;

    alu_vec_t alu_tbl[23];
    cmp_vec_t cmp_tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        alu_tbl[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        alu_tbl[1]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        alu_tbl[2]  = '{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        alu_tbl[3]  = '{4'd2,  32'h00000001, 32'h00000021, 32'h00000002};
        alu_tbl[4]  = '{4'd2,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
        alu_tbl[5]  = '{4'd6,  32'h80000000, 32'h00000004, 32'h08000000};
        alu_tbl[6]  = '{4'd7,  32'h80000000, 32'h00000004, 32'hF8000000};
        alu_tbl[7]  = '{4'd7,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF};
        alu_tbl[8]  = '{4'd7,  32'h70000000, 32'h00000004, 32'h07000000};
        alu_tbl[9]  = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        alu_tbl[10] = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        alu_tbl[11] = '{4'd3,  32'h80000000, 32'h00000001, 32'h00000001};
        alu_tbl[12] = '{4'd4,  32'h80000000, 32'h00000001, 32'h00000000};
        alu_tbl[13] = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        alu_tbl[14] = '{4'd8,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0};
        alu_tbl[15] = '{4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        alu_tbl[16] = '{4'd10, 32'hAAAAAAAA, 32'h12345000, 32'h12345000};
        alu_tbl[17] = '{4'd15, 32'h00000001, 32'h00000002, 32'h00000000};
        alu_tbl[18] = '{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        alu_tbl[19] = '{4'd4,  32'h00000001, 32'hFFFFFFFF, 32'h00000001};
        alu_tbl[20] = '{4'd3,  32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        alu_tbl[21] = '{4'd6,  32'h80000000, 32'h0000003F, 32'h00000001};
        alu_tbl[22] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};

        cmp_tbl[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        cmp_tbl[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000001, 1'b1};
        cmp_tbl[2]  = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b1};
        cmp_tbl[3]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        cmp_tbl[4]  = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        cmp_tbl[5]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 1'b1};
        cmp_tbl[6]  = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        cmp_tbl[7]  = '{3'b011, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        cmp_tbl[8]  = '{3'b000, 32'h00000005, 32'h00000005, 1'b1};
        cmp_tbl[9]  = '{3'b101, 32'h00000005, 32'h00000005, 1'b1};
        cmp_tbl[10] = '{3'b111, 32'h00000005, 32'h00000005, 1'b1};
        cmp_tbl[11] = '{3'b001, 32'h00000005, 32'h00000005, 1'b0};
        cmp_tbl[12] = '{3'b100, 32'h00000005, 32'h00000005, 1'b0};
        cmp_tbl[13] = '{3'b110, 32'h00000005, 32'h00000005, 1'b0};
        cmp_tbl[14] = '{3'b010, 32'h00000001, 32'h00000002, 1'b0};
        cmp_tbl[15] = '{3'b011, 32'h00000001, 32'h00000002, 1'b0};

        // Reset state, with the combinational path tracking inputs meanwhile.
        rst_n    = 1'b0;
        in1      = 32'd2;
        in2      = 32'd3;
        alu_op   = 4'd0;
        cmp_a    = 32'd7;
        cmp_b    = 32'd7;
        funct3   = 3'b000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("reset_result_q", result_q, 32'd0);
        chk("reset_cond_q",   {31'd0, cond_q}, 32'd0);
        chk("reset_valid_q",  {31'd0, valid_q}, 32'd0);
        chk("reset_comb_result", result, 32'd5);
        chk("reset_comb_cond",   {31'd0, cond}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU vectors: combinational check, then registered check after the edge.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            alu_op   = alu_tbl[i].op;
            in1      = alu_tbl[i].a;
            in2      = alu_tbl[i].b;
            in_valid = i[0];
            #1;
            chk($sformatf("alu_result[%0d]", i), result, alu_tbl[i].exp);
            @(posedge clk); #1;
            chk($sformatf("alu_result_q[%0d]", i), result_q, alu_tbl[i].exp);
            chk($sformatf("alu_valid_q[%0d]", i), {31'd0, valid_q}, {31'd0, i[0]});
        end

        // Comparator vectors, with ALU operands held at an unrelated value.
        in1    = 32'h00000005;
        in2    = 32'h00000005;
        alu_op = 4'd1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            funct3 = cmp_tbl[i].f3;
            cmp_a  = cmp_tbl[i].a;
            cmp_b  = cmp_tbl[i].b;
            #1;
            chk($sformatf("cmp_cond[%0d]", i), {31'd0, cond}, {31'd0, cmp_tbl[i].exp});
            chk($sformatf("cmp_alu_indep[%0d]", i), result, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("cmp_cond_q[%0d]", i), {31'd0, cond_q}, {31'd0, cmp_tbl[i].exp});
        end

        // Mid-cycle asynchronous reset, then recapture after release.
        @(negedge clk);
        alu_op   = 4'd0;
        in1      = 32'd2;
        in2      = 32'd3;
        cmp_a    = 32'd9;
        cmp_b    = 32'd9;
        funct3   = 3'b000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("pre_arst_result_q", result_q, 32'd5);
        chk("pre_arst_valid_q",  {31'd0, valid_q}, 32'd1);
        chk("pre_arst_cond_q",   {31'd0, cond_q}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_result_q", result_q, 32'd0);
        chk("arst_cond_q",   {31'd0, cond_q}, 32'd0);
        chk("arst_valid_q",  {31'd0, valid_q}, 32'd0);
        @(posedge clk); #1;
        chk("arst_hold_result_q", result_q, 32'd0);
        chk("arst_hold_valid_q",  {31'd0, valid_q}, 32'd0);
        chk("arst_comb_result",   result, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_arst_result_q", result_q, 32'd5);
        chk("post_arst_valid_q",  {31'd0, valid_q}, 32'd1);
        chk("post_arst_cond_q",   {31'd0, cond_q}, 32'd1);

        // Capture is not gated by in_valid.
        @(negedge clk);
        in1      = 32'd1;
        in2      = 32'd1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("novalid_result_q", result_q, 32'd2);
        chk("novalid_valid_q",  {31'd0, valid_q}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
